// File: rtl/intv_cart_loader.sv
// Intellivision cartridge loader: turns the HPS ioctl byte stream (.ROM container
// with per-segment CRC-16, or a raw .BIN/.INT image) into 16-bit memory word writes.
module intv_cart_loader #(
    parameter logic [15:0] RAW_BASE = 16'h5000,
    parameter logic [7:0]  ROM_IDX  = 8'h01
) (
    input  logic        clksys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        fmt_err,
    output logic        crc_err,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_SEG_S, S_SEG_E, S_DATA_H, S_DATA_L,
        S_WR, S_CRC_H, S_CRC_L, S_TAIL, S_RAW_H, S_RAW_L, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        rom_q, rom_d;
    logic        dl_q, dl_d;
    logic        end_pend_q, end_pend_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  nseg_q, nseg_d;
    logic [15:0] end_q, end_d;
    logic [15:0] crc_q, crc_d;
    logic        wait_q, wait_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fmt_q, fmt_d;
    logic        crc_err_q, crc_err_d;

    logic        dl_rise, dl_fall, byte_v;
    logic [7:0]  nseg_inv;
    logic [15:0] crc_next;
    logic        unused_idx;

    // CRC-16/CCITT, poly 0x1021, MSB first, one whole byte per call.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    // A strobe arriving while we hold off the HPS is a protocol violation and is dropped.
    assign byte_v     = ioctl_wr & ~wait_q;
    assign nseg_inv   = ~nseg_q;
    assign crc_next   = crc_byte(crc_q, ioctl_dout);
    assign unused_idx = ^ioctl_index[7:6];

    assign ioctl_wait = wait_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fmt_err    = fmt_q;
    assign crc_err    = crc_err_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clksys) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rom_q      <= 1'b0;
            // Tracking the live level keeps a download held across reset from restarting a load.
            dl_q       <= ioctl_download;
            end_pend_q <= 1'b0;
            hi_q       <= 8'h00;
            nseg_q     <= 8'h00;
            end_q      <= 16'h0000;
            crc_q      <= 16'hFFFF;
            wait_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fmt_q      <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_q      <= rom_d;
            dl_q       <= dl_d;
            end_pend_q <= end_pend_d;
            hi_q       <= hi_d;
            nseg_q     <= nseg_d;
            end_q      <= end_d;
            crc_q      <= crc_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fmt_q      <= fmt_d;
            crc_err_q  <= crc_err_d;
        end
    end

    // Memory handshake: mem_we/addr/data stay stable until a cycle with mem_ack high
    // (ack may coincide with the first mem_we cycle); ioctl_wait mirrors the pending write.
    always_comb begin
        state_d    = state_q;
        rom_d      = rom_q;
        dl_d       = ioctl_download;
        end_pend_d = end_pend_q;
        hi_d       = hi_q;
        nseg_d     = nseg_q;
        end_d      = end_q;
        crc_d      = crc_q;
        wait_d     = wait_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fmt_d      = fmt_q;
        crc_err_d  = crc_err_q;

        case (state_q)
            S_IDLE: begin
                if (dl_rise) begin
                    done_d    = 1'b0;
                    fmt_d     = 1'b0;
                    crc_err_d = 1'b0;
                    busy_d    = 1'b1;
                    rom_d     = (ioctl_index[5:0] == ROM_IDX[5:0]);
                    if (ioctl_index[5:0] == ROM_IDX[5:0]) begin
                        state_d = S_HDR0;
                    end else begin
                        state_d = S_RAW_H;
                        addr_d  = RAW_BASE;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            S_WR: begin
                if (dl_fall) end_pend_d = 1'b1;
                if (mem_ack) begin
                    we_d   = 1'b0;
                    wait_d = 1'b0;
                    addr_d = addr_q + 16'd1;
                    if (end_pend_q || dl_fall) begin
                        // Raw mode always holds an even byte count here; ROM mode is mid-segment.
                        state_d    = S_IDLE;
                        end_pend_d = 1'b0;
                        if (rom_q) begin
                            fmt_d  = 1'b1;
                            done_d = 1'b0;
                        end else begin
                            done_d = ~crc_err_q;
                        end
                    end else if (!rom_q) begin
                        state_d = S_RAW_H;
                    end else if (addr_q == end_q) begin
                        state_d = S_CRC_H;
                    end else begin
                        state_d = S_DATA_H;
                    end
                end
            end

            default: begin
                if (dl_fall) begin
                    state_d = S_IDLE;
                    if (state_q == S_TAIL || state_q == S_RAW_H) begin
                        done_d = ~crc_err_q;
                    end else begin
                        fmt_d  = 1'b1;
                        done_d = 1'b0;
                    end
                end else if (byte_v) begin
                    case (state_q)
                        S_HDR0: begin
                            if (ioctl_dout == 8'hA8) begin
                                state_d = S_HDR1;
                            end else begin
                                state_d = S_ERR;
                                fmt_d   = 1'b1;
                            end
                        end
                        S_HDR1: begin
                            nseg_d  = ioctl_dout;
                            state_d = S_HDR2;
                        end
                        S_HDR2: begin
                            if (ioctl_dout != nseg_inv) begin
                                state_d = S_ERR;
                                fmt_d   = 1'b1;
                            end else if (nseg_q == 8'h00) begin
                                state_d = S_TAIL;
                            end else begin
                                state_d = S_SEG_S;
                            end
                        end
                        S_SEG_S: begin
                            addr_d  = {ioctl_dout, 8'h00};
                            state_d = S_SEG_E;
                        end
                        S_SEG_E: begin
                            if (ioctl_dout < addr_q[15:8]) begin
                                state_d = S_ERR;
                                fmt_d   = 1'b1;
                            end else begin
                                end_d   = {ioctl_dout, 8'hFF};
                                crc_d   = 16'hFFFF;
                                state_d = S_DATA_H;
                            end
                        end
                        S_DATA_H: begin
                            hi_d    = ioctl_dout;
                            crc_d   = crc_next;
                            state_d = S_DATA_L;
                        end
                        S_DATA_L: begin
                            data_d  = {hi_q, ioctl_dout};
                            crc_d   = crc_next;
                            we_d    = 1'b1;
                            wait_d  = 1'b1;
                            state_d = S_WR;
                        end
                        S_CRC_H: begin
                            hi_d    = ioctl_dout;
                            state_d = S_CRC_L;
                        end
                        S_CRC_L: begin
                            if ({hi_q, ioctl_dout} != crc_q) crc_err_d = 1'b1;
                            nseg_d  = nseg_q - 8'd1;
                            state_d = (nseg_q == 8'd1) ? S_TAIL : S_SEG_S;
                        end
                        S_RAW_H: begin
                            hi_d    = ioctl_dout;
                            state_d = S_RAW_L;
                        end
                        S_RAW_L: begin
                            data_d  = {hi_q, ioctl_dout};
                            we_d    = 1'b1;
                            wait_d  = 1'b1;
                            state_d = S_WR;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_intv_cart_loader.sv
// Bench for intv_cart_loader: directed and random loads, each checked against a
// file-level parse of the same byte stream.
module tb_intv_cart_loader;

    localparam logic [15:0] RAW_BASE = 16'h5000;

    logic        clksys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        ioctl_wait;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack = 1'b0;
    logic        busy, done, fmt_err, crc_err;
    logic [3:0]  dbg_state;

    intv_cart_loader #(.RAW_BASE(RAW_BASE), .ROM_IDX(8'h01)) dut (
        .clksys(clksys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .busy(busy), .done(done), .fmt_err(fmt_err), .crc_err(crc_err),
        .dbg_state(dbg_state)
    );

    always #5 clksys = ~clksys;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  file_q[$];
    logic [31:0] exp_q[$];
    logic        exp_done, exp_fmt, exp_crc;
    bit          ack_en = 1'b1;
    bit          inject_bad = 1'b0;
    int          stall_left = 0;
    int          writes_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-16/CCITT reference.
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Parse file_q as the HPS would send it; produce expected writes and final flags.
    task automatic model_load(input bit rom);
        int          p, n, nseg;
        logic [15:0] st, en, c, rx;
        logic [7:0]  inv;
        exp_q.delete();
        exp_done = 1'b0; exp_fmt = 1'b0; exp_crc = 1'b0;
        n = file_q.size();
        if (!rom) begin
            for (int k = 0; k + 1 < n; k += 2)
                exp_q.push_back({16'(RAW_BASE + 16'(k / 2)), file_q[k], file_q[k + 1]});
            exp_fmt  = (n % 2) != 0;
            exp_done = !exp_fmt;
            return;
        end
        if (n < 3) begin exp_fmt = 1'b1; return; end
        inv = ~file_q[1];
        if (file_q[0] != 8'hA8 || file_q[2] != inv) begin exp_fmt = 1'b1; return; end
        nseg = int'(file_q[1]);
        p = 3;
        for (int s = 0; s < nseg; s++) begin
            if (p + 2 > n) begin exp_fmt = 1'b1; return; end
            st = {file_q[p], 8'h00};
            en = {file_q[p + 1], 8'hFF};
            p += 2;
            if (en < st) begin exp_fmt = 1'b1; return; end
            c = 16'hFFFF;
            for (int a = int'(st); a <= int'(en); a++) begin
                if (p + 2 > n) begin exp_fmt = 1'b1; return; end
                exp_q.push_back({16'(a), file_q[p], file_q[p + 1]});
                c = crc_upd(crc_upd(c, file_q[p]), file_q[p + 1]);
                p += 2;
            end
            if (p + 2 > n) begin exp_fmt = 1'b1; return; end
            rx = {file_q[p], file_q[p + 1]};
            p += 2;
            if (rx != c) exp_crc = 1'b1;
        end
        exp_done = !exp_crc;
    endtask

    task automatic rom_header(input int nseg);
        file_q.delete();
        file_q.push_back(8'hA8);
        file_q.push_back(8'(nseg));
        file_q.push_back(8'(~nseg));
    endtask

    task automatic add_seg(input logic [7:0] sb, input logic [7:0] eb, input bit seq, input bit bad);
        logic [15:0] c, d;
        int          nw;
        file_q.push_back(sb);
        file_q.push_back(eb);
        c  = 16'hFFFF;
        nw = (int'(eb) - int'(sb) + 1) * 256;
        for (int w = 0; w < nw; w++) begin
            d = seq ? 16'(w) : 16'($urandom);
            file_q.push_back(d[15:8]);
            file_q.push_back(d[7:0]);
            c = crc_upd(crc_upd(c, d[15:8]), d[7:0]);
        end
        if (bad) c = c ^ 16'h00FF;
        file_q.push_back(c[15:8]);
        file_q.push_back(c[7:0]);
    endtask

    task automatic add_tail();
        for (int i = 0; i < 16; i++) file_q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        while (ioctl_wait && guard < 300) begin
            if (inject_bad) begin
                inject_bad = 1'b0;
                ioctl_wr   = 1'b1;
                ioctl_dout = 8'hEE;
            end
            @(negedge clksys);
            ioctl_wr = 1'b0;
            guard++;
        end
        if (guard >= 300) check_eq("wait_timeout", 32'(guard), 0);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clksys);
        ioctl_wr = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] idx);
        bit   rom;
        logic pend;
        int   guard;
        rom = (idx[5:0] == 6'h01);
        model_load(rom);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clksys);
        check_eq("busy_start", 32'(busy), 1);
        check_eq("flags_clr", {29'd0, done, fmt_err, crc_err}, 0);
        for (int i = 0; i < file_q.size(); i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clksys);
            send_byte(file_q[i]);
            if (!rom && (i % 2) == 1) begin
                check_eq("lat_we", 32'(mem_we), 1);
                check_eq("lat_addr", 32'(mem_addr), 32'(16'(RAW_BASE + 16'(i / 2))));
            end
        end
        pend = mem_we;
        ioctl_download = 1'b0;
        if (!pend) begin
            @(negedge clksys);
            check_eq("busy_tail", 32'(busy), 1);
            @(negedge clksys);
            check_eq("busy_drop", 32'(busy), 0);
        end else begin
            guard = 0;
            while (busy && guard < 200) begin
                @(negedge clksys);
                guard++;
            end
            check_eq("idle_wait", 32'(busy), 0);
        end
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("fmt_err", 32'(fmt_err), 32'(exp_fmt));
        check_eq("crc_err", 32'(crc_err), 32'(exp_crc));
        check_eq("writes_left", 32'(exp_q.size()), 0);
        check_eq("end_we", {30'd0, mem_we, ioctl_wait}, 0);
        repeat (2) @(negedge clksys);
    endtask

    // Memory side: random ack delay, optional forced stall, scoreboard on every accepted write.
    always @(negedge clksys) begin
        logic [31:0] e;
        mem_ack = 1'b0;
        if (ack_en && mem_we) begin
            if (stall_left > 0) begin
                check_eq("stall_wait", 32'(ioctl_wait), 1);
                if (exp_q.size() != 0) begin
                    check_eq("stall_addr", 32'(mem_addr), 32'(exp_q[0][31:16]));
                    check_eq("stall_data", 32'(mem_data), 32'(exp_q[0][15:0]));
                end
                stall_left--;
            end else if ($urandom_range(0, 2) != 0) begin
                mem_ack = 1'b1;
                writes_seen++;
                check_eq("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), 32'(e[31:16]));
                    check_eq("wr_data", 32'(mem_data), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] idx, sb;
        int         ns, len, ws;

        repeat (3) @(negedge clksys);
        check_eq("rst_out", {26'd0, ioctl_wait, mem_we, busy, done, fmt_err, crc_err}, 0);
        check_eq("rst_bus", {mem_addr, mem_data}, 0);
        reset_n = 1'b1;
        @(negedge clksys);

        // Raw mode, four bytes.
        file_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_load(8'h00);

        // ROM, one 256-word segment, good CRC; first write stalled 5 cycles with a stray strobe.
        rom_header(1); add_seg(8'h50, 8'h50, 1'b1, 1'b0); add_tail();
        stall_left = 5; inject_bad = 1'b1;
        run_load(8'h01);
        check_eq("stall_used", 32'(stall_left), 0);

        // Same file, CRC low byte flipped.
        rom_header(1); add_seg(8'h50, 8'h50, 1'b1, 1'b1); add_tail();
        run_load(8'h01);

        // Header checksum mismatch.
        file_q = '{8'hA8, 8'h02, 8'hFE, 8'h50, 8'h50, 8'h00, 8'h01};
        run_load(8'h01);

        // End page below start page.
        file_q = '{8'hA8, 8'h01, 8'hFE, 8'h50, 8'h4F, 8'h00, 8'h01};
        run_load(8'h01);

        // No segments, only the enable table.
        rom_header(0); add_tail();
        run_load(8'h01);

        // Odd raw byte count.
        file_q = '{8'h01, 8'h02, 8'h03};
        run_load(8'h05);

        // Download aborted in the middle of a segment.
        rom_header(1); add_seg(8'h60, 8'h60, 1'b0, 1'b0);
        while (file_q.size() > 105) void'(file_q.pop_back());
        run_load(8'h01);

        // Random loads.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                ns = $urandom_range(0, 2);
                rom_header(ns);
                for (int s = 0; s < ns; s++) begin
                    sb = 8'($urandom);
                    add_seg(sb, sb, 1'b0, $urandom_range(0, 3) == 0);
                end
                add_tail();
                if ($urandom_range(0, 3) == 0) begin
                    len = $urandom_range(0, file_q.size() - 1);
                    while (file_q.size() > len) void'(file_q.pop_back());
                end
                run_load({2'($urandom), 6'h01});
            end else begin
                len = $urandom_range(1, 24);
                file_q.delete();
                for (int i = 0; i < len; i++) file_q.push_back(8'($urandom));
                idx = 8'($urandom);
                if (idx[5:0] == 6'h01) idx[0] = 1'b0;
                run_load(idx);
            end
        end

        // Reset while a write is pending: everything clears, later bytes write nothing.
        ack_en = 1'b0;
        exp_q.delete();
        ioctl_index = 8'h00;
        ioctl_download = 1'b1;
        @(negedge clksys);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clksys);
        check_eq("rst_pre_we", 32'(mem_we), 1);
        reset_n = 1'b0;
        @(negedge clksys);
        check_eq("midrst_out", {26'd0, ioctl_wait, mem_we, busy, done, fmt_err, crc_err}, 0);
        check_eq("midrst_bus", {mem_addr, mem_data}, 0);
        reset_n = 1'b1;
        ack_en = 1'b1;
        ws = writes_seen;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        repeat (3) @(negedge clksys);
        check_eq("midrst_nowr", 32'(writes_seen), 32'(ws));
        check_eq("midrst_we", 32'(mem_we), 0);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clksys);
        check_eq("midrst_end", {29'd0, busy, done, fmt_err}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intv_cart_loader.md
Name: intv_cart_loader

Overview:
- Sits between the HPS ioctl download stream and the cartridge memory port of intv_core.
- Parses the Intellicart ".ROM" container: header, segments, per-segment CRC-16. Alternatively accepts raw ".BIN/.INT" images.
- Emits 16-bit word writes at Intellivision addresses, back-pressuring ioctl with ioctl_wait.
- Reports done and error status to the core and the OSD.

Parameters:
- RAW_BASE, 16'h5000, word address of the first word in raw mode.
- ROM_IDX, 8'h01, ioctl_index[5:0] value selecting .ROM container parsing; any other index means raw mode.

Ports:
- clksys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  high for the whole transfer.
- ioctl_index  in  8  file type selector.
- ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid with it.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  high means the HPS must hold off the next ioctl_wr.
- mem_we  out  1  word write request, held until acknowledged.
- mem_addr  out  16  word address.
- mem_data  out  16  word data.
- mem_ack  in  1  memory accepted the write; may come in the same cycle as mem_we.
- busy  out  1  a load is in progress; holds the core in reset.
- done  out  1  the last load completed without error.
- fmt_err  out  1  bad header or truncated file.
- crc_err  out  1  a segment CRC mismatched; sticky until the next download.

Behaviour:
- Reset values:
  - ioctl_wait=0, mem_we=0, mem_addr=0, mem_data=0.
  - busy=0, done=0, fmt_err=0, crc_err=0.
  - state=IDLE.
  - Reset mid-load aborts silently; no further writes are issued.
- Start of load:
  - A rising edge of ioctl_download clears done/fmt_err/crc_err and sets busy.
  - Mode is latched from ioctl_index[5:0]==ROM_IDX[5:0].
  - Next state is HDR0 (ROM mode) or RAW_H (raw mode).
- Raw mode:
  - Bytes pair big-endian: the first byte is the high byte.
  - On the second byte: mem_addr=RAW_BASE+word_count, mem_we=1, ioctl_wait=1. State goes to WR.
  - Address wraps modulo 2^16.
- ROM mode states:
  - HDR0: byte must be 8'hA8, else ERR.
  - HDR1: latch nseg.
  - HDR2: byte must equal ~nseg, else ERR. If nseg==0, go to TAIL.
  - SEG_S: start=byte<<8.
  - SEG_E: end=byte<<8 | 8'hFF. If end<start, go to ERR.
  - Clear crc to 16'hFFFF, then go to DATA_H.
  - DATA_H, then DATA_L: assemble a word, write it at addr (starting at start), go to WR.
  - WR: hold mem_we/ioctl_wait until mem_ack.
    - On ack, drop both in the next cycle and increment addr.
    - If the written addr==end, go to CRC_H; otherwise go back to DATA_H (raw mode: back to RAW_H).
  - CRC_H, then CRC_L:
    - Compare the received big-endian value with crc.
    - On mismatch set crc_err and continue loading.
    - Decrement nseg. If zero, go to TAIL; else go to SEG_S.
  - TAIL: ignore all bytes; this covers the 16-byte enable table and any padding.
- CRC rules:
  - CRC-16/CCITT, poly 16'h1021, MSB-first.
  - Updated combinationally, one full byte per consumed data byte (8 unrolled shift steps).
  - Covers data bytes only, not the start/end bytes.
- End of load (ioctl_download falls):
  - In TAIL, or in raw mode with an even byte count: done = !crc_err.
  - Any other state, including a pending WR: fmt_err=1, done=0.
    - A pending write still completes first; then state goes to IDLE.
  - An odd raw byte count: the final byte is dropped and fmt_err=1.
  - busy falls one cycle after the state reaches IDLE.
- ERR: fmt_err=1. Ignore bytes until ioctl_download falls, then go to IDLE.
- Byte handling:
  - ioctl_wr while ioctl_wait=1 is a protocol violation; the byte is dropped.
  - ioctl_wr in IDLE is ignored.
  - A byte is consumed in the same cycle as ioctl_wr.
- Latency: mem_we rises 1 cycle after the second byte of a word.
- Simultaneous events: mem_ack in the same cycle as an ioctl_download fall completes the write first.

Test Plan:
- Raw mode, index 0, bytes 12 34 AB CD: required response is writes (5000,1234) then (5001,ABCD), done=1, fmt_err=0.
- ROM file A8 01 FE, segment 50 50, 256 words 0000..00FF, correct CRC, 16-byte table:
  - Required: 256 writes at addresses 5000..50FF.
  - done=1, crc_err=0.
- Same file with the CRC low byte flipped: all 256 writes still occur, crc_err=1, done=0.
- Header A8 02 FE (checksum mismatch): no writes, fmt_err=1 after ioctl_download falls, busy drops.
- mem_ack held low 5 cycles during the first write: ioctl_wait=1 and mem_we=1 stable for 5 cycles, address does not advance, no byte is lost.
- Download aborted in the middle of a segment: fmt_err=1, done=0. Then reset_n is pulsed low during a second load: all outputs return to reset values within 1 cycle.
